// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR coefficient loader: FSM states,
// control/status bit positions and default sizing.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } fir_state_e;

  localparam int CTRL_RUN          = 0;
  localparam int CTRL_LOAD_START   = 1;
  localparam int CTRL_COEFF_TOGGLE = 2;
  localparam int CTRL_SOFT_CLEAR   = 3;
  localparam int CTRL_BITS         = 4;

  localparam int STAT_LOAD      = 0;
  localparam int STAT_READY     = 1;
  localparam int STAT_RUN       = 2;
  localparam int STAT_ERROR     = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_SUM_LSB   = 16;

  localparam int DEF_MAX_TAPS    = 64;
  localparam int DEF_COEFF_WIDTH = 16;

  function automatic logic [7:0] sat_count(input logic [7:0] cnt, input logic [7:0] lim);
    return (cnt > lim) ? lim : cnt;
  endfunction

endpackage

// File: rtl/fir_ctrl_edge.sv
// Registers the control bits and reports rising edges and any-change events
// against the registered copy (same clock domain, no synchronisers).
module fir_ctrl_edge #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] ctrl_i,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] change_o
);

  logic [W-1:0] ctrl_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ctrl_q <= '0;
    else          ctrl_q <= ctrl_i;
  end

  assign rise_o   = ctrl_i & ~ctrl_q;
  assign change_o = ctrl_i ^ ctrl_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// Sequences coefficient writes into a FIR core and gates its run enable.
// Optional running checksum on status[31:16] when FIR_COEFF_CHECKSUM_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing loaded, waiting for load_start
// ST_LOAD  | one coefficient written per coeff_toggle change
// ST_READY | all taps loaded, FIR stopped; reload or run allowed
// ST_RUN   | FIR enabled while run stays high
// ST_ERROR | bad tap count requested; only soft_clear/reset leave
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int MAX_TAPS    = DEF_MAX_TAPS,
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic [DATA_WIDTH-1:0]  control_axi,
  input  logic [DATA_WIDTH-1:0]  tap_count_axi,
  input  logic [DATA_WIDTH-1:0]  coeff_axi,
  output logic [DATA_WIDTH-1:0]  status_axi,
  output logic                   coeff_wr_en,
  output logic [7:0]             coeff_wr_addr,
  output logic [COEFF_WIDTH-1:0] coeff_wr_data,
  output logic [7:0]             fir_tap_count,
  output logic                   fir_enable
);

  fir_state_e             state_q, state_d;
  logic [7:0]             idx_q, idx_d;
  logic [7:0]             tap_q, tap_d;
  logic                   wr_en_q, wr_en_d;
  logic [7:0]             addr_q, addr_d;
  logic [COEFF_WIDTH-1:0] data_q, data_d;
  logic                   en_q, en_d;
  logic [DATA_WIDTH-1:0]  status_q, status_d;

  logic [CTRL_BITS-1:0] ctrl_rise, ctrl_chg;
  logic soft_clear, load_req, load_ok, write_req, last_write;

  fir_ctrl_edge #(.W(CTRL_BITS)) u_ctrl_edge (
    .clk_i    (S_AXI_ACLK),
    .rst_n_i  (S_AXI_ARESETN),
    .ctrl_i   (control_axi[CTRL_BITS-1:0]),
    .rise_o   (ctrl_rise),
    .change_o (ctrl_chg)
  );

  assign soft_clear = ctrl_rise[CTRL_SOFT_CLEAR];
  assign load_req   = ctrl_rise[CTRL_LOAD_START] && !soft_clear &&
                      ((state_q == ST_IDLE) || (state_q == ST_READY));
  assign load_ok    = (tap_count_axi >= DATA_WIDTH'(1)) &&
                      (tap_count_axi <= DATA_WIDTH'(MAX_TAPS));
  assign write_req  = (state_q == ST_LOAD) && ctrl_chg[CTRL_COEFF_TOGGLE] && !soft_clear;
  assign last_write = write_req && (idx_q == tap_q - 8'd1);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (soft_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_req) state_d = load_ok ? ST_LOAD : ST_ERROR;
        end
        ST_LOAD: begin
          if (last_write) state_d = ST_READY;
        end
        ST_READY: begin
          if (load_req)                   state_d = load_ok ? ST_LOAD : ST_ERROR;
          else if (control_axi[CTRL_RUN]) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!control_axi[CTRL_RUN]) state_d = ST_READY;
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

`ifdef FIR_COEFF_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [31:0] coeff_ext;

  assign coeff_ext = 32'(coeff_axi[COEFF_WIDTH-1:0]);

  always_comb begin
    sum_d = sum_q;
    if (soft_clear || load_req) sum_d = 16'd0;
    else if (write_req)         sum_d = sum_q + coeff_ext[15:0];
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) sum_q <= 16'd0;
    else                sum_q <= sum_d;
  end

  logic unused_coeff_ext;
  assign unused_coeff_ext = ^coeff_ext[31:16];
`endif

  always_comb begin
    idx_d   = idx_q;
    tap_d   = tap_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (soft_clear) begin
      idx_d = 8'd0;
      tap_d = 8'd0;
    end else if (load_req) begin
      idx_d = 8'd0;
      if (load_ok) tap_d = tap_count_axi[7:0];
    end else if (write_req) begin
      wr_en_d = 1'b1;
      addr_d  = idx_q;
      data_d  = coeff_axi[COEFF_WIDTH-1:0];
      idx_d   = idx_q + 8'd1;
    end
    en_d = (state_d == ST_RUN);

    // Status mirrors the state being entered so it lines up with the outputs.
    status_d = '0;
    status_d[STAT_LOAD]  = (state_d == ST_LOAD);
    status_d[STAT_READY] = (state_d == ST_READY);
    status_d[STAT_RUN]   = (state_d == ST_RUN);
    status_d[STAT_ERROR] = (state_d == ST_ERROR);
    status_d[STAT_COUNT_LSB +: 8] = sat_count(idx_d, tap_d);
`ifdef FIR_COEFF_CHECKSUM_EN
    status_d[STAT_SUM_LSB +: 16] = sum_d;
`endif
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      idx_q    <= 8'd0;
      tap_q    <= 8'd0;
      wr_en_q  <= 1'b0;
      addr_q   <= 8'd0;
      data_q   <= '0;
      en_q     <= 1'b0;
      status_q <= '0;
    end else begin
      idx_q    <= idx_d;
      tap_q    <= tap_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      en_q     <= en_d;
      status_q <= status_d;
    end
  end

  assign status_axi    = status_q;
  assign coeff_wr_en   = wr_en_q;
  assign coeff_wr_addr = addr_q;
  assign coeff_wr_data = data_q;
  assign fir_tap_count = tap_q;
  assign fir_enable    = en_q;

  logic unused_ctrl;
  assign unused_ctrl = ^{control_axi[DATA_WIDTH-1:CTRL_BITS],
                         ctrl_rise[CTRL_RUN], ctrl_rise[CTRL_COEFF_TOGGLE],
                         ctrl_chg[CTRL_RUN], ctrl_chg[CTRL_LOAD_START],
                         ctrl_chg[CTRL_SOFT_CLEAR]};

  if (COEFF_WIDTH < DATA_WIDTH) begin : g_coeff_hi
    logic unused_coeff_hi;
    assign unused_coeff_hi = ^coeff_axi[DATA_WIDTH-1:COEFF_WIDTH];
  end

endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter MAX_TAPS, default 64, the maximum tap count accepted (legal range 1..255).
REQ-002 SHALL have parameter COEFF_WIDTH, default 16, the coefficient width in bits (max 32).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, the register word width.
REQ-004 SHALL have port S_AXI_ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port S_AXI_ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port control_axi, input, DATA_WIDTH: control word. [0] run, [1] load_start (rising edge), [2] coeff_toggle (any change), [3] soft_clear (rising edge).
REQ-007 SHALL have port tap_count_axi, input, DATA_WIDTH: requested tap count.
REQ-008 SHALL have port coeff_axi, input, DATA_WIDTH: staged coefficient in bits [COEFF_WIDTH-1:0].
REQ-009 SHALL have port status_axi, output, DATA_WIDTH: status word, registered.
REQ-010 SHALL have port coeff_wr_en, output, 1 bit: one-cycle coefficient write strobe to the FIR core.
REQ-011 SHALL have port coeff_wr_addr, output, 8 bits: tap index of the coefficient being written.
REQ-012 SHALL have port coeff_wr_data, output, COEFF_WIDTH: coefficient value being written.
REQ-013 SHALL have port fir_tap_count, output, 8 bits: tap count latched at load start.
REQ-014 SHALL have port fir_enable, output, 1 bit: FIR run enable.

Function
REQ-015 SHALL register control_axi each cycle and detect edges/changes against the registered copy; all inputs are same-domain, so no synchronisers.
REQ-016 SHALL implement FSM states IDLE, LOAD, READY, RUN, ERROR.
REQ-017 SHALL, in IDLE or READY on a load_start edge, go to LOAD with index=0 and latch fir_tap_count if tap_count_axi is in 1..MAX_TAPS; otherwise it SHALL go to ERROR.
REQ-018 SHALL, in LOAD on each coeff_toggle change, assert coeff_wr_en for exactly one cycle, starting the cycle after the change is detected, with addr=index and data=coeff_axi[COEFF_WIDTH-1:0], then increment index.
REQ-019 SHALL go from LOAD to READY in the same cycle as the write with index == fir_tap_count-1.
REQ-020 SHALL ignore coeff_toggle changes outside LOAD (no write, no state change).
REQ-021 SHALL go from READY to RUN when run=1, and from RUN to READY when run=0; fir_enable=1 only in RUN.
REQ-022 SHALL ignore load_start in LOAD, RUN and ERROR.
REQ-023 SHALL, on a soft_clear edge in any state, go to IDLE, zero index, the loaded count and fir_tap_count, and suppress any coeff_wr_en for that cycle; soft_clear has the highest priority.
REQ-024 SHALL leave ERROR only via soft_clear or reset.
REQ-025 SHALL drive status_axi as: [0] LOAD, [1] READY, [2] RUN, [3] ERROR, [15:8] coefficients loaded (saturates at fir_tap_count), [31:16] per REQ-029; all other bits 0.

Reset
REQ-026 SHALL, while S_AXI_ARESETN=0, force state IDLE and all outputs, counters and the registered control copy to 0.
REQ-027 SHALL, on reset asserted mid-LOAD, discard the partial load; after release the block is in IDLE with count 0.

Configuration
REQ-028 SHALL use macro FIR_COEFF_CHECKSUM_EN to compile the checksum feature in or out.
REQ-029 SHALL, with FIR_COEFF_CHECKSUM_EN defined, keep a 16-bit wrapping sum of written coefficients (low 16 bits of each), cleared at load start, soft_clear and reset, and drive it on status_axi[31:16]; without the macro, [31:16] SHALL be 0 and no adder SHALL be synthesised.

Structure
REQ-030 SHALL take the FSM state typedef, the control bit indices, the status bit indices and the default MAX_TAPS/COEFF_WIDTH constants from shared package fir_pkg.
REQ-031 SHALL instantiate one sub-module, fir_ctrl_edge, for registered rising-edge and change detection of control bits.

Verification
REQ-032 SHALL cover: tap_count=3, load_start, then toggles with coeff 0x0011, 0x0022, 0x0033 -> writes to addr 0,1,2, each one cycle after its toggle; status=0x0302; checksum 0x0066 when enabled.
REQ-033 SHALL cover: tap_count=0 or MAX_TAPS+1 with load_start -> ERROR, status[3]=1, no writes; soft_clear -> IDLE, status=0.
REQ-034 SHALL cover: READY with run=1 -> fir_enable=1 and status[2]=1; run=0 -> READY; load_start while in RUN -> ignored.
REQ-035 SHALL cover: soft_clear edge coincident with a toggle in LOAD -> no coeff_wr_en, IDLE, count 0.
REQ-036 SHALL cover: async reset asserted mid-LOAD after 2 of 4 writes -> outputs 0 immediately; after release, stray toggle -> no write.
